// File: rtl/err_cnt_bank.sv
// Per-channel saturating error counters with preset, read-and-clear,
// threshold alarms and a saturating grand total of counted events.
module err_cnt_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int TOT_W  = 32,
  parameter int CH_W   = 2
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25,
  input  logic [NUM_CH-1:0] inc,
  input  logic              set_en,
  input  logic [CH_W-1:0]   set_ch,
  input  logic [CNT_W-1:0]  set_val,
  input  logic              rd_req,
  input  logic              rd_clr,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  input  logic [CNT_W-1:0]  thresh,
  output logic [NUM_CH-1:0] alarm,
  output logic [TOT_W-1:0]  tot_cnt,
  input  logic              tot_clr,
  output logic [NUM_CH-1:0] sat
);

  localparam int PC_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_sat;
  logic [NUM_CH-1:0] r_alarm;
  logic [TOT_W-1:0]  r_tot;
  logic [CNT_W-1:0]  r_rd_data;
  logic              r_rd_valid;

  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_sat_nxt;
  logic [NUM_CH-1:0] w_alarm_nxt;
  logic [NUM_CH-1:0] w_counted;
  logic [PC_W-1:0]   w_pop;
  logic [CNT_W-1:0]  w_rd_val;
  logic [TOT_W-1:0]  w_tot_base;
  logic [TOT_W:0]    w_tot_sum;
  logic [TOT_W-1:0]  w_tot_nxt;

  // Priority per channel: preset, then read-clear (keeps same-cycle inc), then inc.
  always_comb begin
    w_counted = '0;
    w_sat_nxt = r_sat;
    w_alarm_nxt = '0;
    w_pop = '0;
    w_rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (set_en && (set_ch == CH_W'(i))) begin
        w_cnt_nxt[i] = set_val;
        w_sat_nxt[i] = 1'b0;
      end else if (rd_req && rd_clr && (rd_ch == CH_W'(i))) begin
        w_cnt_nxt[i] = inc[i] ? CNT_W'(1) : '0;
        w_sat_nxt[i] = 1'b0;
        w_counted[i] = inc[i];
      end else if (inc[i]) begin
        if (r_cnt[i] != CNT_MAX) begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          w_counted[i] = 1'b1;
        end else begin
          w_sat_nxt[i] = 1'b1;
        end
      end
      w_alarm_nxt[i] = (thresh != '0) && (w_cnt_nxt[i] >= thresh);
      w_pop = w_pop + PC_W'(w_counted[i]);
      if (rd_ch == CH_W'(i)) w_rd_val = r_cnt[i];
    end
  end

  always_comb begin
    w_tot_base = tot_clr ? '0 : r_tot;
    w_tot_sum = {1'b0, w_tot_base} + (TOT_W+1)'(w_pop);
    w_tot_nxt = w_tot_sum[TOT_W] ? '1 : w_tot_sum[TOT_W-1:0];
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      r_sat <= '0;
      r_alarm <= '0;
      r_tot <= '0;
      r_rd_data <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_sat <= w_sat_nxt;
      r_alarm <= w_alarm_nxt;
      r_tot <= w_tot_nxt;
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_data <= w_rd_val;
    end
  end

  assign rd_data = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign alarm = r_alarm;
  assign tot_cnt = r_tot;
  assign sat = r_sat;

endmodule

// File: tb/tb_err_cnt_bank.sv
// Directed bench for err_cnt_bank: counting, preset, read-clear, saturation,
// alarms, total clear and mid-run reset, with hand-computed expectations.
module tb_err_cnt_bank;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25;
  logic [3:0]  inc;
  logic        set_en;
  logic [1:0]  set_ch;
  logic [15:0] set_val;
  logic        rd_req;
  logic        rd_clr;
  logic [1:0]  rd_ch;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [15:0] thresh;
  logic [3:0]  alarm;
  logic [31:0] tot_cnt;
  logic        tot_clr;
  logic [3:0]  sat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_156m25 = ~clk_156m25;

  err_cnt_bank #(.NUM_CH(4), .CNT_W(16), .TOT_W(32), .CH_W(2)) dut (
    .clk_156m25(clk_156m25), .reset_156m25(reset_156m25), .inc(inc),
    .set_en(set_en), .set_ch(set_ch), .set_val(set_val),
    .rd_req(rd_req), .rd_clr(rd_clr), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_valid(rd_valid), .thresh(thresh),
    .alarm(alarm), .tot_cnt(tot_cnt), .tot_clr(tot_clr), .sat(sat)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_156m25);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_156m25 = 1'b1; inc = '0; set_en = 1'b0; set_ch = '0; set_val = '0;
    rd_req = 1'b0; rd_clr = 1'b0; rd_ch = '0; thresh = '0; tot_clr = 1'b0;
    tick(2);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_tot", tot_cnt, 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    reset_156m25 = 1'b0;

    // ch0 five increments, ch2 three
    inc = 4'b0101; tick(3);
    inc = 4'b0001; tick(2);
    inc = 4'b0000;
    chk("t1_tot", tot_cnt, 32'd8);
    chk("t1_valid_idle", 32'(rd_valid), 32'd0);
    rd_req = 1'b1; rd_ch = 2'd0; tick();
    chk("t1_rd0_valid", 32'(rd_valid), 32'd1);
    chk("t1_rd0_data", 32'(rd_data), 32'd5);
    rd_ch = 2'd2; tick();
    chk("t1_rd2_valid", 32'(rd_valid), 32'd1);
    chk("t1_rd2_data", 32'(rd_data), 32'd3);
    rd_req = 1'b0; tick();
    chk("t1_valid_drop", 32'(rd_valid), 32'd0);
    chk("t1_data_hold", 32'(rd_data), 32'd3);

    // ch1 saturation
    set_en = 1'b1; set_ch = 2'd1; set_val = 16'hFFFE; tick();
    set_en = 1'b0;
    inc = 4'b0010; tick(3);
    inc = 4'b0000;
    chk("t2_sat", 32'(sat), 32'b0010);
    chk("t2_tot", tot_cnt, 32'd9);
    rd_req = 1'b1; rd_clr = 1'b1; rd_ch = 2'd1; tick();
    chk("t2_rc_data", 32'(rd_data), 32'hFFFF);
    chk("t2_sat_clr", 32'(sat), 32'd0);
    rd_clr = 1'b0; tick();
    chk("t2_after_clr", 32'(rd_data), 32'd0);
    rd_req = 1'b0;

    // ch3 read-clear with coincident increment
    inc = 4'b1000; tick(7);
    chk("t3_tot_pre", tot_cnt, 32'd16);
    rd_req = 1'b1; rd_clr = 1'b1; rd_ch = 2'd3; tick();
    chk("t3_rc_data", 32'(rd_data), 32'd7);
    chk("t3_tot", tot_cnt, 32'd17);
    inc = 4'b0000; rd_clr = 1'b0; tick();
    chk("t3_reread", 32'(rd_data), 32'd1);

    // alarm on ch0 at threshold 4
    rd_clr = 1'b1; rd_ch = 2'd0; tick();
    chk("t4_rc0_data", 32'(rd_data), 32'd5);
    rd_req = 1'b0; rd_clr = 1'b0;
    thresh = 16'd4; inc = 4'b0001; tick(3);
    chk("t4_alarm_below", 32'(alarm), 32'd0);
    tick();
    chk("t4_alarm_rise", 32'(alarm), 32'b0001);
    chk("t4_tot", tot_cnt, 32'd21);
    inc = 4'b0000; thresh = 16'd0; tick();
    chk("t4_alarm_fall", 32'(alarm), 32'd0);

    // preset beats read-clear on ch2; dropped inc not totalled
    inc = 4'b0100; tick(6);
    chk("t5_tot_pre", tot_cnt, 32'd27);
    set_en = 1'b1; set_ch = 2'd2; set_val = 16'd20;
    rd_req = 1'b1; rd_clr = 1'b1; rd_ch = 2'd2; tick();
    chk("t5_rd_old", 32'(rd_data), 32'd9);
    chk("t5_tot", tot_cnt, 32'd27);
    set_en = 1'b0; rd_clr = 1'b0; inc = 4'b0000; tick();
    chk("t5_preset_val", 32'(rd_data), 32'd20);
    rd_req = 1'b0;

    // tot_clr is clear-then-add
    tot_clr = 1'b1; inc = 4'b0001; tick();
    tot_clr = 1'b0;
    chk("t6_totclr", tot_cnt, 32'd1);

    // build to 12 with alarms on, then reset mid-read
    thresh = 16'd2;
    inc = 4'b1111; tick(2);
    inc = 4'b0111; tick();
    inc = 4'b0000;
    chk("t7_tot", tot_cnt, 32'd12);
    chk("t7_alarm", 32'(alarm), 32'b1111);
    reset_156m25 = 1'b1; rd_req = 1'b1; rd_ch = 2'd2; tick();
    reset_156m25 = 1'b0;
    chk("t7_rst_valid", 32'(rd_valid), 32'd0);
    chk("t7_rst_data", 32'(rd_data), 32'd0);
    chk("t7_rst_tot", tot_cnt, 32'd0);
    chk("t7_rst_alarm", 32'(alarm), 32'd0);
    chk("t7_rst_sat", 32'(sat), 32'd0);
    rd_ch = 2'd2; tick();
    chk("t7_rd2_valid", 32'(rd_valid), 32'd1);
    chk("t7_rd2_zero", 32'(rd_data), 32'd0);
    rd_ch = 2'd0; tick();
    chk("t7_rd0_zero", 32'(rd_data), 32'd0);
    rd_req = 1'b0; thresh = 16'd0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
